// File: rtl/mux8_to_1_pkg.sv
// mux8_to_1_pkg: shared sizes and named select codes for the registered 8-to-1 mux
package mux8_to_1_pkg;
   localparam int N_IN  = 8;
   localparam int SEL_W = 3;
   localparam logic [SEL_W-1:0] SEL_A = 3'd0;
   localparam logic [SEL_W-1:0] SEL_B = 3'd1;
   localparam logic [SEL_W-1:0] SEL_C = 3'd2;
   localparam logic [SEL_W-1:0] SEL_D = 3'd3;
   localparam logic [SEL_W-1:0] SEL_E = 3'd4;
   localparam logic [SEL_W-1:0] SEL_F = 3'd5;
   localparam logic [SEL_W-1:0] SEL_G = 3'd6;
   localparam logic [SEL_W-1:0] SEL_H = 3'd7;
endpackage

// File: rtl/mux8_to_1_if.sv
// mux8_to_1_if: data/select/enable bundle; sel_onehot exists only with MUX8_TO_1_ONEHOT_EN
interface mux8_to_1_if
   import mux8_to_1_pkg::*;
#(
   parameter int WIDTH = 1
) ();
   logic             en;
   logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] y;
`ifdef MUX8_TO_1_ONEHOT_EN
   logic [N_IN-1:0]  sel_onehot;
   modport master (output en, a, b, c, d, e, f, g, h, sel, input y, sel_onehot);
   modport slave  (input en, a, b, c, d, e, f, g, h, sel, output y, sel_onehot);
`else
   modport master (output en, a, b, c, d, e, f, g, h, sel, input y);
   modport slave  (input en, a, b, c, d, e, f, g, h, sel, output y);
`endif
endinterface

// File: rtl/mux8_to_1_core.sv
// mux8_to_1_core: stateless 8-way select of WIDTH-bit inputs
module mux8_to_1_core
   import mux8_to_1_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   input  logic [WIDTH-1:0] i_e,
   input  logic [WIDTH-1:0] i_f,
   input  logic [WIDTH-1:0] i_g,
   input  logic [WIDTH-1:0] i_h,
   input  logic [SEL_W-1:0] i_sel,
   output logic [WIDTH-1:0] o_y_comb
);
   // every code decoded; an unknown sel falls back to input a
   always_comb begin
      o_y_comb = i_a;
      case (i_sel)
         SEL_A:   o_y_comb = i_a;
         SEL_B:   o_y_comb = i_b;
         SEL_C:   o_y_comb = i_c;
         SEL_D:   o_y_comb = i_d;
         SEL_E:   o_y_comb = i_e;
         SEL_F:   o_y_comb = i_f;
         SEL_G:   o_y_comb = i_g;
         SEL_H:   o_y_comb = i_h;
         default: o_y_comb = i_a;
      endcase
   end
endmodule

// File: rtl/mux8_to_1.sv
// mux8_to_1: registered 8-to-1 mux with enable and async active-low reset; MUX8_TO_1_ONEHOT_EN adds a registered one-hot sel
module mux8_to_1
   import mux8_to_1_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   mux8_to_1_if.slave bus
);
   logic [WIDTH-1:0] w_y_comb;
   logic [WIDTH-1:0] r_y;

   mux8_to_1_core #(.WIDTH(WIDTH)) u_core (
      .i_a      (bus.a),
      .i_b      (bus.b),
      .i_c      (bus.c),
      .i_d      (bus.d),
      .i_e      (bus.e),
      .i_f      (bus.f),
      .i_g      (bus.g),
      .i_h      (bus.h),
      .i_sel    (bus.sel),
      .o_y_comb (w_y_comb)
   );

   // capture the selected input when enabled, otherwise hold
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)      r_y <= '0;
      else if (bus.en) r_y <= w_y_comb;

   assign bus.y = r_y;

`ifdef MUX8_TO_1_ONEHOT_EN
   logic [N_IN-1:0] r_onehot;

   // one-hot decode of sel, same enable and reset behaviour as y
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)      r_onehot <= '0;
      else if (bus.en) r_onehot <= {{(N_IN-1){1'b0}}, 1'b1} << bus.sel;

   assign bus.sel_onehot = r_onehot;
`endif
endmodule

// File: tb/tb_mux8_to_1.sv
// tb_mux8_to_1: random + directed checks of WIDTH=8 and WIDTH=1 instances against an array-indexed model
module tb_mux8_to_1;
   import mux8_to_1_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [2:0] sel = 3'd0;
   logic [7:0] din[8];
   logic [7:0] din1 = 8'd0;
   logic       chk = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   logic [7:0] exp8 = 8'd0;
   logic       exp1 = 1'b0;
   logic [7:0] exp_oh = 8'd0;

   always #5 clk = ~clk;

   mux8_to_1_if #(.WIDTH(8)) bus8 ();
   mux8_to_1_if #(.WIDTH(1)) bus1 ();

   assign bus8.en = en;
   assign bus8.sel = sel;
   assign bus8.a = din[0];
   assign bus8.b = din[1];
   assign bus8.c = din[2];
   assign bus8.d = din[3];
   assign bus8.e = din[4];
   assign bus8.f = din[5];
   assign bus8.g = din[6];
   assign bus8.h = din[7];
   assign bus1.en = en;
   assign bus1.sel = sel;
   assign bus1.a = din1[0];
   assign bus1.b = din1[1];
   assign bus1.c = din1[2];
   assign bus1.d = din1[3];
   assign bus1.e = din1[4];
   assign bus1.f = din1[5];
   assign bus1.g = din1[6];
   assign bus1.h = din1[7];

   mux8_to_1 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   mux8_to_1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // reference: the enabled edge stores input number sel; reset clears everything at once
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         exp8   <= 8'd0;
         exp1   <= 1'b0;
         exp_oh <= 8'd0;
      end else if (en) begin
         exp8   <= din[sel];
         exp1   <= din1[sel];
         exp_oh <= 8'd1 << sel;
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // compare both instances with the model every cycle, away from the rising edge
   always @(negedge clk)
      if (chk) begin
         check("y8_vs_model", 32'(bus8.y), 32'(exp8));
         check("y1_vs_model", 32'(bus1.y), 32'(exp1));
`ifdef MUX8_TO_1_ONEHOT_EN
         check("onehot_vs_model", 32'(bus8.sel_onehot), 32'(exp_oh));
`endif
      end

   initial begin
      logic [10:0] v;
      for (int k = 0; k < 8; k++) din[k] = 8'd0;
      #1 rst_n = 1'b0;
      #1 check("reset_y8", 32'(bus8.y), 32'd0);
      check("reset_y1", 32'(bus1.y), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      chk = 1'b1;

      // reset behaviour
      en = 1'b1; sel = SEL_A; din1 = 8'h01; din[0] = 8'hA5;
      step();
      check("first_capture_y1", 32'(bus1.y), 32'd1);
      check("first_capture_y8", 32'(bus8.y), 32'hA5);
      #2 rst_n = 1'b0;
      #1 check("async_clear_y1", 32'(bus1.y), 32'd0);
      check("async_clear_y8", 32'(bus8.y), 32'd0);
      step();
      check("held_in_reset_y1", 32'(bus1.y), 32'd0);
      rst_n = 1'b1;
      step();
      check("capture_after_release", 32'(bus1.y), 32'd1);

      // exhaustive WIDTH=1 sweep, WIDTH=8 data randomised alongside
      for (int i = 0; i < 2048; i++) begin
         v = i[10:0];
         for (int k = 0; k < 8; k++) begin
            din1[k] = v[10-k];
            din[k]  = 8'($urandom);
         end
         sel = v[2:0];
         en  = 1'b1;
         step();
         if (v == 11'b10000000_000) begin
            check("ex_a_sel0_y", 32'(bus1.y), 32'd1);
            check("ex_a_sel0_model", 32'(exp1), 32'd1);
         end
         if (v == 11'b00000001_111) check("ex_h_sel7_y", 32'(bus1.y), 32'd1);
         if (v == 11'b01111111_000) check("ex_a0_sel0_y", 32'(bus1.y), 32'd0);
      end

      // enable hold
      din1 = 8'h00; din1[3] = 1'b1; sel = SEL_D; en = 1'b1;
      step();
      check("hold_capture", 32'(bus1.y), 32'd1);
      en = 1'b0; din1[3] = 1'b0; sel = SEL_G; din1[6] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_en0", 32'(bus1.y), 32'd1);
      end
      en = 1'b1;
      step();
      check("reenable", 32'(bus1.y), 32'd0);

      // latency: change right after an edge, result appears at the following edge
      din1 = 8'h00; sel = SEL_C; en = 1'b1;
      step();
      @(posedge clk);
      #1 sel = SEL_H; din1[7] = 1'b1;
      #2 check("latency_before_edge", 32'(bus1.y), 32'd0);
      @(posedge clk);
      #1 check("latency_after_edge", 32'(bus1.y), 32'd1);
      @(negedge clk);

      // WIDTH=8 sweep with fixed pattern
      for (int k = 0; k < 8; k++) din[k] = 8'(8'h11 * (k + 1));
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         step();
         check("w8_sweep", 32'(bus8.y), 32'(8'h11 * (s + 1)));
`ifdef MUX8_TO_1_ONEHOT_EN
         check("onehot_sweep", 32'(bus8.sel_onehot), 32'(8'd1 << s));
`endif
      end
      sel = SEL_F;
      step();
      check("w8_sel5_model", 32'(exp8), 32'h66);
`ifdef MUX8_TO_1_ONEHOT_EN
      check("onehot_sel5", 32'(bus8.sel_onehot), 32'h20);
      #2 rst_n = 1'b0;
      #1 check("onehot_reset", 32'(bus8.sel_onehot), 32'h00);
      step();
      rst_n = 1'b1;
`endif

      // random traffic with random enable and occasional mid-cycle reset pulses
      for (int i = 0; i < 400; i++) begin
         en   = 1'($urandom_range(0, 1));
         sel  = 3'($urandom);
         din1 = 8'($urandom);
         for (int k = 0; k < 8; k++) din[k] = 8'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         step();
      end

      chk = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mux8_to_1.md
Name: mux8_to_1

Overview:
- Registered 8-to-1 multiplexer. A 3-bit select chooses one of eight data inputs (a..h), and the result is captured in an output register on the rising clock edge.
- Leaf datapath block; usable directly on the Basys-3 board top, with inputs from switches or upstream logic and output to LED or downstream logic.
- Data width is parameterised; default 1 bit.

Parameters:
- WIDTH, 1, bit width of each data input and of y.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; y loads only when en=1.
- a  input  WIDTH  data input 0, selected when sel=3'd0.
- b  input  WIDTH  data input 1, sel=3'd1.
- c  input  WIDTH  data input 2, sel=3'd2.
- d  input  WIDTH  data input 3, sel=3'd3.
- e  input  WIDTH  data input 4, sel=3'd4.
- f  input  WIDTH  data input 5, sel=3'd5.
- g  input  WIDTH  data input 6, sel=3'd6.
- h  input  WIDTH  data input 7, sel=3'd7.
- sel  input  3  select code, unsigned binary.
- y  output  WIDTH  registered selected data.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - rst_n=0 forces y to all-zeros immediately, independent of clk.
  - y stays zero while rst_n=0.
  - Deassertion is taken synchronously at the next rising clk edge.
- Selection is a pure combinational function: sel=0→a, 1→b, 2→c, 3→d, 4→e, 5→f, 6→g, 7→h.
- No illegal codes exist; all 8 sel values are decoded explicitly.
- X/Z on sel must not propagate as a latched value. The default branch selects a.
- Capture: on a rising clk edge with rst_n=1 and en=1, y <= selected input.
- Hold: with en=0, y holds its previous value.
- Latency: exactly 1 clk cycle from a stable {sel, inputs} to y.
- Throughput: one new selection per cycle.
- Sel and data changing on the same cycle: the value sampled at the edge is used. There is no priority between them.
- Reset mid-operation: y clears asynchronously. The first capture after release occurs on the first edge with rst_n=1 and en=1.
- Each bit is selected independently across WIDTH; no arithmetic is performed.
- No latches; a single always_ff holds the y register.

Optional Feature:
- Macro MUX8_TO_1_ONEHOT_EN.
- When defined:
  - Adds output sel_onehot [7:0]: registered one-hot decode of sel, updated under the same en and reset rules as y.
  - Reset value is 8'b0000_0000.
  - sel=3'd5 gives 8'b0010_0000.
- When undefined: the port and its logic are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package mux8_to_1_pkg:
  - N_IN=8, SEL_W=3.
  - Named select constants SEL_A=3'd0 … SEL_H=3'd7.
- One combinational sub-module, mux8_to_1_core:
  - Parameter WIDTH.
  - Inputs a..h and sel; output y_comb.
  - Contains no state.
- The top mux8_to_1 holds only the register, enable, reset and the optional one-hot decode.

Test Plan:
1. Reset: rst_n=0 mid-cycle with y=1 → y=0 before the next edge; held while low. Release, then en=1, sel=0, a=1 → y=1 after 1 edge.
2. Exhaustive (WIDTH=1): loop i=0..2047, {a,b,c,d,e,f,g,h,sel}=i, en=1, one edge each → y equals bit (7-sel) of i[10:3].
   - Example: i=11'b10000000_000 → y=1.
   - Example: i=11'b00000001_111 → y=1.
   - Example: i=11'b01111111_000 → y=0.
3. Enable hold: capture sel=3, d=1 → y=1. Then en=0, d=0, sel=6, g=0 for 3 edges → y stays 1. Re-enable → y=0 on the next edge.
4. Latency: change sel from 2 to 7 with c=0, h=1 just after an edge → y still 0 until the next edge, then 1.
5. WIDTH=8: a=8'h11 … h=8'h88, sweep sel 0..7 → y=8'h11,8'h22,…,8'h88 each one cycle later.
6. With MUX8_TO_1_ONEHOT_EN defined: sel=0..7 → sel_onehot=8'h01,8'h02,…,8'h80. Reset → 8'h00.
